// File: rtl/bus_arbiter2_pkg.sv
// -----------------------------------------------------------------------------
// bus_arbiter2_pkg
// Shared definitions for the two-master bus arbiter: FSM state encoding,
// bus widths and the read-data value returned when a slave access times out.
// No ports; imported by bus_arbiter2 and its testbench.
// -----------------------------------------------------------------------------
package bus_arbiter2_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int LANE_W = 4;

  // Read data handed back to a master whose transfer was ended by timeout.
  localparam logic [DATA_W-1:0] TIMEOUT_FILL = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } arbState_e;

endpackage

// File: rtl/bus_arbiter2.sv
// -----------------------------------------------------------------------------
// bus_arbiter2
// Arbitrates two masters onto one shared slave. One transfer is outstanding at
// a time; simultaneous requests alternate (round-robin on the last owner). The
// slave request is fully registered, and completion is reported to the owning
// master with a one-cycle ready pulse plus registered read data. An optional
// wait-cycle timeout ends a stuck transfer with all-ones read data.
//
// Parameters
//   TIMEOUT      maximum slave wait cycles, 0 disables the timeout
// Ports
//   clk, rst                     clock, asynchronous active-high reset
//   m0_* / m1_*  (in)            addr, dout, wr, lane, valid of each master
//   m0_din/m1_din, m0_ready/m1_ready (out)  read data and completion pulse
//   s_addr, s_dout, s_wr, s_lane, s_valid (out)  registered slave request
//   s_din, s_ready (in)          slave read data and completion
//   owner (out)                  master currently or last granted
//   busy (out)                   arbiter not idle
//   timeout_err (out)            one-cycle pulse on a timed-out completion
// -----------------------------------------------------------------------------
module bus_arbiter2
  import bus_arbiter2_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,

  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_dout,
  input  logic              m0_wr,
  input  logic [LANE_W-1:0] m0_lane,
  input  logic              m0_valid,
  output logic [DATA_W-1:0] m0_din,
  output logic              m0_ready,

  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_dout,
  input  logic              m1_wr,
  input  logic [LANE_W-1:0] m1_lane,
  input  logic              m1_valid,
  output logic [DATA_W-1:0] m1_din,
  output logic              m1_ready,

  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_dout,
  output logic              s_wr,
  output logic [LANE_W-1:0] s_lane,
  output logic              s_valid,
  input  logic [DATA_W-1:0] s_din,
  input  logic              s_ready,

  output logic              owner,
  output logic              busy,
  output logic              timeout_err
);

  // The wait counter is at least 8 bits wide and grows if TIMEOUT needs more.
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);
  localparam bit TIMEOUT_EN = (TIMEOUT > 0);

  arbState_e         state_q, state_d;
  logic [ADDR_W-1:0] sAddr_q, sAddr_d;
  logic [DATA_W-1:0] sDout_q, sDout_d;
  logic              sWr_q, sWr_d;
  logic [LANE_W-1:0] sLane_q, sLane_d;
  logic              sValid_q, sValid_d;
  logic              owner_q, owner_d;
  logic [CNT_W-1:0]  waitCnt_q, waitCnt_d;
  logic [DATA_W-1:0] m0Din_q, m0Din_d;
  logic [DATA_W-1:0] m1Din_q, m1Din_d;
  logic              m0Ready_q, m0Ready_d;
  logic              m1Ready_q, m1Ready_d;
  logic              timeoutErr_q, timeoutErr_d;

  logic              grantIdx;
  logic              completeNow;
  logic              timedOut;
  logic [DATA_W-1:0] returnData;

  // State register. Reset leaves owner at 1 so that the first tie after reset
  // is granted to master 0. Reset mid-transfer simply drops everything; the
  // ready registers clear, so the abandoned transfer never completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      sAddr_q      <= '0;
      sDout_q      <= '0;
      sWr_q        <= 1'b0;
      sLane_q      <= '0;
      sValid_q     <= 1'b0;
      owner_q      <= 1'b1;
      waitCnt_q    <= '0;
      m0Din_q      <= '0;
      m1Din_q      <= '0;
      m0Ready_q    <= 1'b0;
      m1Ready_q    <= 1'b0;
      timeoutErr_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sAddr_q      <= sAddr_d;
      sDout_q      <= sDout_d;
      sWr_q        <= sWr_d;
      sLane_q      <= sLane_d;
      sValid_q     <= sValid_d;
      owner_q      <= owner_d;
      waitCnt_q    <= waitCnt_d;
      m0Din_q      <= m0Din_d;
      m1Din_q      <= m1Din_d;
      m0Ready_q    <= m0Ready_d;
      m1Ready_q    <= m1Ready_d;
      timeoutErr_q <= timeoutErr_d;
    end
  end

  // Next-state logic. Everything holds by default except the pulse outputs,
  // which default low so that ready and timeout_err last exactly one cycle.
  // IDLE grants (round-robin on a tie) and latches the winner's request;
  // BUSY waits for the slave or for the timeout; DONE is a fixed turnaround
  // cycle giving the finished master time to drop its valid.
  always_comb begin
    state_d      = state_q;
    sAddr_d      = sAddr_q;
    sDout_d      = sDout_q;
    sWr_d        = sWr_q;
    sLane_d      = sLane_q;
    sValid_d     = sValid_q;
    owner_d      = owner_q;
    waitCnt_d    = waitCnt_q;
    m0Din_d      = m0Din_q;
    m1Din_d      = m1Din_q;
    m0Ready_d    = 1'b0;
    m1Ready_d    = 1'b0;
    timeoutErr_d = 1'b0;
    grantIdx     = owner_q;
    completeNow  = 1'b0;
    timedOut     = 1'b0;
    returnData   = s_din;

    case (state_q)
      S_IDLE: begin
        if (m0_valid || m1_valid) begin
          grantIdx = (m0_valid && m1_valid) ? ~owner_q : m1_valid;
          if (grantIdx) begin
            sAddr_d = m1_addr;
            sDout_d = m1_dout;
            sWr_d   = m1_wr;
            sLane_d = m1_lane;
          end else begin
            sAddr_d = m0_addr;
            sDout_d = m0_dout;
            sWr_d   = m0_wr;
            sLane_d = m0_lane;
          end
          sValid_d  = 1'b1;
          owner_d   = grantIdx;
          waitCnt_d = '0;
          state_d   = S_BUSY;
        end
      end

      S_BUSY: begin
        // A slave response on the same cycle the limit is hit wins over the
        // timeout, since it is checked first.
        if (s_ready && sValid_q) begin
          completeNow = 1'b1;
        end else begin
          waitCnt_d = waitCnt_q + 1'b1;
          if (TIMEOUT_EN && (waitCnt_d == CNT_LIMIT)) begin
            completeNow = 1'b1;
            timedOut    = 1'b1;
            returnData  = TIMEOUT_FILL;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Completion only touches the owner's data and ready; the other master's
    // returned data keeps its old value.
    if (completeNow) begin
      sValid_d     = 1'b0;
      timeoutErr_d = timedOut;
      state_d      = S_DONE;
      if (owner_q) begin
        m1Din_d   = returnData;
        m1Ready_d = 1'b1;
      end else begin
        m0Din_d   = returnData;
        m0Ready_d = 1'b1;
      end
    end
  end

  assign s_addr      = sAddr_q;
  assign s_dout      = sDout_q;
  assign s_wr        = sWr_q;
  assign s_lane      = sLane_q;
  assign s_valid     = sValid_q;
  assign m0_din      = m0Din_q;
  assign m1_din      = m1Din_q;
  assign m0_ready    = m0Ready_q;
  assign m1_ready    = m1Ready_q;
  assign owner       = owner_q;
  assign timeout_err = timeoutErr_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_bus_arbiter2.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter2
// Randomised scoreboard bench for bus_arbiter2 (TIMEOUT = 4). The stimulus
// process plays both masters and the slave, and a transaction-level model
// decides on which clock edge each grant and each completion must happen.
// Expected slave requests and master completions are queued; a monitor on the
// falling edge pops and compares them whenever the DUT raises s_valid or a
// ready/timeout pulse.
// -----------------------------------------------------------------------------
module tb_bus_arbiter2;
  import bus_arbiter2_pkg::*;

  localparam int TIMEOUT    = 4;
  localparam int NUM_CYCLES = 3000;
  localparam int DRAIN      = 40;

  logic        clk, rst;
  logic [31:0] m0_addr, m0_dout, m0_din, m1_addr, m1_dout, m1_din;
  logic        m0_wr, m0_valid, m0_ready, m1_wr, m1_valid, m1_ready;
  logic [3:0]  m0_lane, m1_lane, s_lane;
  logic [31:0] s_addr, s_dout, s_din;
  logic        s_wr, s_valid, s_ready, owner, busy, timeout_err;

  bus_arbiter2 #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .m0_addr(m0_addr), .m0_dout(m0_dout), .m0_wr(m0_wr), .m0_lane(m0_lane),
    .m0_valid(m0_valid), .m0_din(m0_din), .m0_ready(m0_ready),
    .m1_addr(m1_addr), .m1_dout(m1_dout), .m1_wr(m1_wr), .m1_lane(m1_lane),
    .m1_valid(m1_valid), .m1_din(m1_din), .m1_ready(m1_ready),
    .s_addr(s_addr), .s_dout(s_dout), .s_wr(s_wr), .s_lane(s_lane),
    .s_valid(s_valid), .s_din(s_din), .s_ready(s_ready),
    .owner(owner), .busy(busy), .timeout_err(timeout_err)
  );

  // Free-running clock and a count of rising edges used to time-stamp events.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] dout;
    logic        wr;
    logic [3:0]  lane;
    logic        owner;
    int          edgeIdx;
  } slaveExp_t;

  typedef struct {
    logic        owner;
    logic [31:0] din0;
    logic [31:0] din1;
    logic        tmo;
    int          edgeIdx;
  } respExp_t;

  slaveExp_t slaveQ[$];
  respExp_t  respQ[$];
  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Monitor: whenever s_valid rises, the next expected slave request is due;
  // whenever any completion pulse appears, the next expected response is due.
  // Both carry the edge index they must appear on, so latency is checked too.
  slaveExp_t se;
  respExp_t  re;
  logic      prevSValid = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if (s_valid && !prevSValid) begin
        if (slaveQ.size() == 0) begin
          checkOutput("unexpected_s_valid", 32'd1, 32'd0);
        end else begin
          se = slaveQ.pop_front();
          checkOutput("s_addr", s_addr, se.addr);
          checkOutput("s_dout", s_dout, se.dout);
          checkOutput("s_wr", 32'(s_wr), 32'(se.wr));
          checkOutput("s_lane", 32'(s_lane), 32'(se.lane));
          checkOutput("owner", 32'(owner), 32'(se.owner));
          checkOutput("grant_cycle", cyc, se.edgeIdx);
        end
      end
      if (m0_ready || m1_ready || timeout_err) begin
        if (respQ.size() == 0) begin
          checkOutput("unexpected_ready", 32'd1, 32'd0);
        end else begin
          re = respQ.pop_front();
          checkOutput("m0_ready", 32'(m0_ready), 32'(re.owner == 1'b0));
          checkOutput("m1_ready", 32'(m1_ready), 32'(re.owner == 1'b1));
          checkOutput("timeout_err", 32'(timeout_err), 32'(re.tmo));
          checkOutput("m0_din", m0_din, re.din0);
          checkOutput("m1_din", m1_din, re.din1);
          checkOutput("s_valid_after_done", 32'(s_valid), 32'd0);
          checkOutput("busy_in_done", 32'(busy), 32'd1);
          checkOutput("done_cycle", cyc, re.edgeIdx);
        end
      end
    end
    prevSValid = s_valid;
  end

  // Transaction-level model state: each master is either pending (valid held)
  // or not; the arbiter is either free from some edge on or carrying one
  // transfer that finishes on a known edge.
  logic        pend[2];
  logic [31:0] reqAddr[2], reqDout[2];
  logic        reqWr[2];
  logic [3:0]  reqLane[2];
  logic [31:0] expDin[2];
  logic        lastOwner, curOwner, curTmo, relMaster;
  logic [31:0] slaveDin;
  bit          inXfer, noNew, didReset;
  int          freeEdge, grantEdge, complEdge, relEdge, grantCount;

  task automatic newRequest(input int i);
    pend[i]    = 1'b1;
    reqAddr[i] = $urandom;
    reqDout[i] = $urandom;
    reqWr[i]   = 1'($urandom_range(0, 1));
    reqLane[i] = 4'($urandom_range(1, 15));
  endtask

  task automatic driveMasters();
    m0_valid = pend[0]; m0_addr = reqAddr[0]; m0_dout = reqDout[0];
    m0_wr    = reqWr[0]; m0_lane = reqLane[0];
    m1_valid = pend[1]; m1_addr = reqAddr[1]; m1_dout = reqDout[1];
    m1_wr    = reqWr[1]; m1_lane = reqLane[1];
  endtask

  // Decide what happens on edge k, given the inputs that were held for it.
  task automatic evaluateEdge(input int k);
    logic g;
    int   lat;
    if (inXfer && k == complEdge) begin
      inXfer    = 1'b0;
      relEdge   = k + 1;
      relMaster = curOwner;
      freeEdge  = k + 2;
    end
    if (!inXfer && k >= freeEdge && (pend[0] || pend[1])) begin
      g = (pend[0] && pend[1]) ? ~lastOwner : pend[1];
      if (grantCount == 0) begin
        lat = 2;
        slaveDin = 32'hDEAD_BEEF;
      end else if (grantCount == 1) begin
        lat = TIMEOUT + 2;
        slaveDin = $urandom;
      end else begin
        lat = $urandom_range(0, TIMEOUT + 1);
        slaveDin = $urandom;
      end
      curTmo = (lat >= TIMEOUT);
      complEdge = curTmo ? k + TIMEOUT : k + 1 + lat;
      expDin[g] = curTmo ? TIMEOUT_FILL : slaveDin;
      slaveQ.push_back('{reqAddr[g], reqDout[g], reqWr[g], reqLane[g], g, k});
      respQ.push_back('{g, expDin[0], expDin[1], curTmo, complEdge});
      lastOwner = g;
      curOwner  = g;
      grantEdge = k;
      inXfer    = 1'b1;
      grantCount++;
    end
  endtask

  // Drive inputs for edge k+1: release a finished master, maybe raise new
  // requests, and have the slave answer exactly when the model says. Outside
  // a busy slave cycle the slave may emit stray ready pulses, which must be
  // ignored.
  task automatic applyStimulus(input int k);
    bit justReleased[2];
    justReleased[0] = 1'b0;
    justReleased[1] = 1'b0;
    if (relEdge == k) begin
      pend[relMaster] = 1'b0;
      justReleased[relMaster] = 1'b1;
    end
    for (int i = 0; i < 2; i++) begin
      if (!noNew && !pend[i] && !justReleased[i] && $urandom_range(0, 3) == 0)
        newRequest(i);
    end
    if (inXfer && !curTmo && k == complEdge - 1) begin
      s_ready = 1'b1;
      s_din   = slaveDin;
    end else begin
      s_ready = (inXfer && k + 1 <= complEdge) ? 1'b0 : ($urandom_range(0, 3) == 0);
      s_din   = $urandom;
    end
    driveMasters();
  endtask

  initial begin
    int k;
    rst = 1'b1;
    s_ready = 1'b0; s_din = '0;
    for (int i = 0; i < 2; i++) begin
      pend[i] = 1'b0; reqAddr[i] = '0; reqDout[i] = '0;
      reqWr[i] = 1'b0; reqLane[i] = '0; expDin[i] = '0;
    end
    driveMasters();
    lastOwner = 1'b1; curOwner = 1'b1; curTmo = 1'b0; relMaster = 1'b0;
    slaveDin = '0; inXfer = 1'b0; noNew = 1'b0; didReset = 1'b0;
    grantEdge = 0; complEdge = 0; relEdge = -1; grantCount = 0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_s_valid", 32'(s_valid), 32'd0);
    checkOutput("rst_s_wr", 32'(s_wr), 32'd0);
    checkOutput("rst_s_lane", 32'(s_lane), 32'd0);
    checkOutput("rst_s_addr", s_addr, 32'd0);
    checkOutput("rst_s_dout", s_dout, 32'd0);
    checkOutput("rst_m0_ready", 32'(m0_ready), 32'd0);
    checkOutput("rst_m1_ready", 32'(m1_ready), 32'd0);
    checkOutput("rst_m0_din", m0_din, 32'd0);
    checkOutput("rst_m1_din", m1_din, 32'd0);
    checkOutput("rst_owner", 32'(owner), 32'd1);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_timeout_err", 32'(timeout_err), 32'd0);

    // Both masters ask at once: a read of 0x100 from m0 and a single-byte
    // write from m1. m0 must win the tie; the first transfer answers after two
    // wait cycles with DEADBEEF, the second one times out.
    rst = 1'b0;
    freeEdge = cyc + 1;
    pend[0] = 1'b1; reqAddr[0] = 32'h100; reqDout[0] = 32'h0;
    reqWr[0] = 1'b0; reqLane[0] = 4'hF;
    pend[1] = 1'b1; reqAddr[1] = 32'h203; reqDout[1] = 32'h1111_1111;
    reqWr[1] = 1'b1; reqLane[1] = 4'b1000;
    driveMasters();

    for (int n = 0; n < NUM_CYCLES + DRAIN; n++) begin
      @(posedge clk);
      #1;
      k = cyc;
      noNew = (n >= NUM_CYCLES);
      evaluateEdge(k);
      // Once, halfway through, pull reset in the middle of a slave wait.
      if (!didReset && n > NUM_CYCLES / 2 && inXfer && grantEdge < k && k + 1 < complEdge) begin
        rst = 1'b1;
        #1;
        checkOutput("midrst_s_valid", 32'(s_valid), 32'd0);
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        checkOutput("midrst_owner", 32'(owner), 32'd1);
        void'(respQ.pop_back());
        inXfer = 1'b0; relEdge = -1; lastOwner = 1'b1;
        pend[0] = 1'b0; pend[1] = 1'b0;
        expDin[0] = '0; expDin[1] = '0;
        s_ready = 1'b0;
        driveMasters();
        @(posedge clk);
        #1;
        rst = 1'b0;
        freeEdge = cyc + 1;
        didReset = 1'b1;
      end else begin
        applyStimulus(k);
      end
    end

    @(negedge clk);
    checkOutput("reset_exercised", 32'(didReset), 32'd1);
    checkOutput("slave_queue_drained", slaveQ.size(), 32'd0);
    checkOutput("resp_queue_drained", respQ.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bus_arbiter2.md
BUS_ARBITER2 -- requirements
Module: bus_arbiter2

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum slave wait cycles; 0 disables timeout.
REQ-002 clk  in  1  clock, all state on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 mN_addr  in  32  master N address (N = 0, 1 throughout).
REQ-005 mN_dout  in  32  master N write data.
REQ-006 mN_wr  in  1  master N write (1) / read (0).
REQ-007 mN_lane  in  4  master N byte-lane enables.
REQ-008 mN_valid  in  1  master N request; held with its fields stable until mN_ready.
REQ-009 mN_din  out  32  read data returned to master N.
REQ-010 mN_ready  out  1  one-cycle completion pulse to master N.
REQ-011 s_addr, s_dout, s_wr, s_lane  out  32/32/1/4  registered request to the shared slave.
REQ-012 s_valid  out  1  registered slave request.
REQ-013 s_din  in  32  slave read data.
REQ-014 s_ready  in  1  slave completion, valid only while s_valid is high.
REQ-015 owner  out  1  index of the master currently or last granted.
REQ-016 busy  out  1  high in any state other than S_IDLE.
REQ-017 timeout_err  out  1  one-cycle pulse when a transfer is ended by timeout.

Function
REQ-018 States: S_IDLE, S_BUSY, S_DONE.
REQ-019 S_IDLE, no mN_valid: remain; s_valid 0.
REQ-020 S_IDLE, exactly one mN_valid: latch that master's addr/dout/wr/lane into s_* regs, set s_valid 1, set owner N, clear the wait counter, go to S_BUSY.
REQ-021 S_IDLE, both valid: grant master !owner (round-robin); after reset the first simultaneous request goes to m0.
REQ-022 S_BUSY, s_ready 1: s_valid 0, mN_din <= s_din for the owner, owner mN_ready 1 for exactly one cycle, go to S_DONE.
REQ-023 S_BUSY, s_ready 0: increment the 8-bit-minimum wait counter; when it reaches TIMEOUT (TIMEOUT>0), complete as REQ-022 with mN_din = 32'hFFFFFFFF and timeout_err 1.
REQ-024 S_DONE: unconditional one-cycle turnaround, so the completed master's valid drops before re-arbitration; then go to S_IDLE.
REQ-025 Latency: mN_valid sampled at edge E -> s_valid at E+1; s_ready sampled at edge K -> mN_ready high in cycle after K; minimum 3 cycles per transfer plus 1 turnaround.
REQ-026 The non-owner's mN_ready is never asserted, and its mN_din holds its previous value.
REQ-027 mN_din for a write completion is s_din unchanged; masters ignore it.
REQ-028 A master deasserting valid before ready (protocol violation) does not abort a latched transfer; it completes normally.
REQ-029 s_ready while s_valid is 0 is ignored.
REQ-030 No combinational path from any mN_* input to any s_* output, or from s_* inputs to mN_* outputs.

Reset
REQ-031 On rst: state S_IDLE, s_valid 0, s_wr 0, s_lane 0, s_addr 0, s_dout 0, m0_ready 0, m1_ready 0, m0_din 0, m1_din 0, owner 1 (so m0 wins first tie), timeout_err 0, wait counter 0.
REQ-032 rst mid-transfer abandons the transfer immediately; no mN_ready is issued for it.

Structure
REQ-033 Shared package holds state encoding (S_IDLE/S_BUSY/S_DONE), bus widths (ADDR_W 32, DATA_W 32, LANE_W 4) and the timeout fill value 32'hFFFFFFFF.
REQ-034 Single flat module; no sub-module; TIMEOUT counter and round-robin bit inline.

Verification
REQ-035 m0 read 0x100, slave ready after 2 cycles with s_din 0xDEADBEEF -> s_addr 0x100, s_wr 0, m0_ready one pulse, m0_din 0xDEADBEEF, m1_ready 0.
REQ-036 m0 and m1 valid same cycle after reset -> m0 granted first, then m1; owner sequence 0,1; each ready exactly once.
REQ-037 m1 holds valid continuously, m0 requests in S_BUSY -> after m1 completes and S_DONE, m0 granted next.
REQ-038 m1 byte write addr 0x203, lane 4'b1000, dout 0x11111111 -> s_lane 4'b1000, s_wr 1, s_dout 0x11111111 on slave.
REQ-039 TIMEOUT 4, slave never ready -> m0_ready and timeout_err pulse after 4 wait cycles, m0_din 0xFFFFFFFF, s_valid 0.
REQ-040 rst asserted in S_BUSY -> s_valid and busy 0 asynchronously, no mN_ready pulse, next request arbitrated normally.
